// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl -- IEEE 1149.1-style TAP controller for the s9234 JTAG wrapper.
//
// Holds the 16-state TAP FSM, the 2-bit instruction register (shift stage
// plus update latch) and the 1-bit bypass register. It sequences the 36-cell
// boundary-scan register (BSR) through capture/shift/update strobes and
// muxes TDO from the selected chain.
//
// Optional feature macro: JTAG_IDCODE_EN
//   When defined, instruction 2'b10 becomes IDCODE instead of INTEST, and a
//   32-bit ID register (loaded with IDCODE_VALUE in Capture-DR) is added.
//   Reset and Test-Logic-Reset then load IDCODE instead of BYPASS.
//
// Ports:
//   TCLK        in   scan clock (only clock)
//   TRST        in   asynchronous active-low reset
//   TMS         in   test mode select, sampled on posedge TCLK
//   TDI         in   test data in
//   bsr_tdo     in   serial output (cell 0) of the BSR chain
//   TDO         out  test data out (combinational)
//   tdo_en      out  high only in Shift-IR / Shift-DR
//   bsr_capture out  BSR parallel-capture strobe
//   bsr_shift   out  BSR shift enable
//   bsr_update  out  BSR update-latch strobe
//   bsr_mode    out  1 = BSR drives core pins (EXTEST/INTEST)
//   ir_out      out  current (updated) instruction
//   tap_state   out  FSM state encoding
module jtag_tap_ctrl #(
    parameter logic [1:0]  IR_CAPTURE   = 2'b01,
    parameter logic [31:0] IDCODE_VALUE = 32'h0000_0001
) (
    input  logic       TCLK,
    input  logic       TRST,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       bsr_tdo,
    output logic       TDO,
    output logic       tdo_en,
    output logic       bsr_capture,
    output logic       bsr_shift,
    output logic       bsr_update,
    output logic       bsr_mode,
    output logic [1:0] ir_out,
    output logic [3:0] tap_state
);

    typedef enum logic [3:0] {
        TLR   = 4'hF, RTI   = 4'hC,
        SELDR = 4'h7, CAPDR = 4'h6, SHDR  = 4'h2, EX1DR = 4'h1,
        PSDR  = 4'h3, EX2DR = 4'h0, UPDDR = 4'h5,
        SELIR = 4'h4, CAPIR = 4'hE, SHIR  = 4'hA, EX1IR = 4'h9,
        PSIR  = 4'hB, EX2IR = 4'h8, UPDIR = 4'hD
    } tap_state_e;

    localparam logic [1:0] IR_EXTEST = 2'b00;
    localparam logic [1:0] IR_BYPASS = 2'b11;
`ifdef JTAG_IDCODE_EN
    localparam logic [1:0] IR_IDCODE = 2'b10;
    localparam logic [1:0] IR_RESET  = IR_IDCODE;
`else
    localparam logic [1:0] IR_INTEST = 2'b10;
    localparam logic [1:0] IR_RESET  = IR_BYPASS;
`endif

    tap_state_e  state_q, state_d;
    logic [1:0]  ir_q, ir_d;
    logic [1:0]  ir_sr_q, ir_sr_d;
    logic        bypass_q, bypass_d;
    logic        bsr_sel;
`ifdef JTAG_IDCODE_EN
    logic [31:0] id_q, id_d;
    logic        id_sel;
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            state_q  <= TLR;
            ir_q     <= IR_RESET;
            ir_sr_q  <= 2'b00;
            bypass_q <= 1'b0;
`ifdef JTAG_IDCODE_EN
            id_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            ir_sr_q  <= ir_sr_d;
            bypass_q <= bypass_d;
`ifdef JTAG_IDCODE_EN
            id_q     <= id_d;
`endif
        end
    end

    // ---------------------------------------------------- next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:   state_d = TMS ? TLR   : RTI;
            RTI:   state_d = TMS ? SELDR : RTI;
            SELDR: state_d = TMS ? SELIR : CAPDR;
            CAPDR: state_d = TMS ? EX1DR : SHDR;
            SHDR:  state_d = TMS ? EX1DR : SHDR;
            EX1DR: state_d = TMS ? UPDDR : PSDR;
            PSDR:  state_d = TMS ? EX2DR : PSDR;
            EX2DR: state_d = TMS ? UPDDR : SHDR;
            UPDDR: state_d = TMS ? SELDR : RTI;
            SELIR: state_d = TMS ? TLR   : CAPIR;
            CAPIR: state_d = TMS ? EX1IR : SHIR;
            SHIR:  state_d = TMS ? EX1IR : SHIR;
            EX1IR: state_d = TMS ? UPDIR : PSIR;
            PSIR:  state_d = TMS ? EX2IR : PSIR;
            EX2IR: state_d = TMS ? UPDIR : SHIR;
            UPDIR: state_d = TMS ? SELDR : RTI;
            default: state_d = TLR;
        endcase
    end

    // -------------------------------------------------- register datapath
    // Pause and exit states fall through the defaults, so they hold.
    always_comb begin
        ir_d     = ir_q;
        ir_sr_d  = ir_sr_q;
        bypass_d = bypass_q;
`ifdef JTAG_IDCODE_EN
        id_d     = id_q;
`endif
        case (state_q)
            TLR:   ir_d    = IR_RESET;
            CAPIR: ir_sr_d = IR_CAPTURE;
            SHIR:  ir_sr_d = {TDI, ir_sr_q[1]};
            UPDIR: ir_d    = ir_sr_q;
            CAPDR: begin
                bypass_d = 1'b0;
`ifdef JTAG_IDCODE_EN
                id_d     = IDCODE_VALUE;
`endif
            end
            SHDR: begin
                bypass_d = TDI;
`ifdef JTAG_IDCODE_EN
                id_d     = {TDI, id_q[31:1]};
`endif
            end
            default: ;
        endcase
    end

    // ------------------------------------------------- instruction decode
    // Decoded from the update latch only, so a new instruction has no effect
    // on the BSR until the Update-IR edge has committed it.
`ifdef JTAG_IDCODE_EN
    assign id_sel   = (ir_q == IR_IDCODE);
    assign bsr_sel  = (ir_q != IR_BYPASS) && !id_sel;
    assign bsr_mode = (ir_q == IR_EXTEST);
`else
    assign bsr_sel  = (ir_q != IR_BYPASS);
    assign bsr_mode = (ir_q == IR_EXTEST) || (ir_q == IR_INTEST);
`endif

    assign bsr_capture = bsr_sel && (state_q == CAPDR);
    assign bsr_shift   = bsr_sel && (state_q == SHDR);
    assign bsr_update  = bsr_sel && (state_q == UPDDR);

    // ------------------------------------------------------------- TDO mux
    always_comb begin
        TDO = 1'b0;
        if (state_q == SHIR) begin
            TDO = ir_sr_q[0];
        end else if (state_q == SHDR) begin
`ifdef JTAG_IDCODE_EN
            TDO = bsr_sel ? bsr_tdo : (id_sel ? id_q[0] : bypass_q);
`else
            TDO = bsr_sel ? bsr_tdo : bypass_q;
`endif
        end
    end

    assign tdo_en    = (state_q == SHIR) || (state_q == SHDR);
    assign ir_out    = ir_q;
    assign tap_state = state_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed testbench for jtag_tap_ctrl with a TDO scoreboard queue.
module tb_jtag_tap_ctrl;

    logic       TCLK = 1'b0;
    logic       TRST = 1'b0;
    logic       TMS  = 1'b1;
    logic       TDI  = 1'b0;
    logic       bsr_tdo = 1'b0;
    logic       TDO, tdo_en, bsr_capture, bsr_shift, bsr_update, bsr_mode;
    logic [1:0] ir_out;
    logic [3:0] tap_state;

`ifdef JTAG_IDCODE_EN
    localparam logic [1:0] IR_RST = 2'b10;
`else
    localparam logic [1:0] IR_RST = 2'b11;
`endif

    int   total = 0;
    int   fails = 0;
    int   upd_cnt = 0;
    int   ncap, nsh, nupd;
    logic exp_q[$];
    logic [1:0] cur_ir;

    jtag_tap_ctrl dut (
        .TCLK(TCLK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .bsr_tdo(bsr_tdo),
        .TDO(TDO), .tdo_en(tdo_en), .bsr_capture(bsr_capture),
        .bsr_shift(bsr_shift), .bsr_update(bsr_update), .bsr_mode(bsr_mode),
        .ir_out(ir_out), .tap_state(tap_state)
    );

    always #5 TCLK = ~TCLK;

    // Update strobes actually consumed by the BSR (high on a rising edge).
    always @(posedge TCLK) if (bsr_update === 1'b1) upd_cnt <= upd_cnt + 1;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for the next rising edge, then settle to mid low phase.
    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCLK);
        @(negedge TCLK);
        #1;
    endtask

    task automatic sample_strobes();
        ncap += int'(bsr_capture);
        nsh  += int'(bsr_shift);
        nupd += int'(bsr_update);
    endtask

    function automatic logic exp_mode(input logic [1:0] ir);
`ifdef JTAG_IDCODE_EN
        return (ir == 2'b00);
`else
        return (ir == 2'b00) || (ir == 2'b10);
`endif
    endfunction

    // IR scan from RTI, ending back in RTI; checks capture pattern on TDO
    // and that ir_out only moves on the edge leaving Update-IR.
    task automatic ir_scan(input logic [1:0] v);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        chk("ir_shift_state", tap_state, 4'hA);
        chk("ir_tdo_en", tdo_en, 1'b1);
        chk("ir_cap_bit0", TDO, 1'b1);
        step(0, v[0]);
        chk("ir_cap_bit1", TDO, 1'b0);
        step(1, v[1]);
        chk("ir_ex1_state", tap_state, 4'h9);
        step(1, 0);
        chk("ir_upd_state", tap_state, 4'hD);
        chk("ir_out_before_upd", ir_out, cur_ir);
        chk("bsr_mode_before_upd", bsr_mode, exp_mode(cur_ir));
        step(0, 0);
        cur_ir = v;
        chk("ir_out_after_upd", ir_out, v);
        chk("bsr_mode_after_upd", bsr_mode, exp_mode(v));
    endtask

    initial begin
        logic [35:0] data;
        logic [3:0]  bits;
        logic [31:0] idv;
        int          u0;

        // ---- reset
        cur_ir = IR_RST;
        repeat (4) @(negedge TCLK);
        #1;
        chk("rst_state", tap_state, 4'hF);
        chk("rst_ir", ir_out, IR_RST);
        chk("rst_strobes", {bsr_capture, bsr_shift, bsr_update}, 3'b000);
        chk("rst_tdo", {TDO, tdo_en}, 2'b00);
        TRST = 1'b1;
        step(1, 0); step(1, 0); step(1, 0);
        chk("tlr_hold", tap_state, 4'hF);
        step(0, 0);
        chk("to_rti", tap_state, 4'hC);

        // ---- five TMS=1 from Shift-DR
        step(1, 0); step(0, 0); step(0, 0);
        chk("reach_shdr", tap_state, 4'h2);
        repeat (5) step(1, 0);
        chk("tms5_state", tap_state, 4'hF);
        chk("tms5_ir", ir_out, IR_RST);
        step(0, 0);

        // ---- load SAMPLE/PRELOAD
        ir_scan(2'b01);

        // ---- BSR DR scan
        data = 36'h0deadbeef;
        ncap = 0; nsh = 0; nupd = 0;
        step(1, 0); sample_strobes();
        step(0, 0); sample_strobes();
        step(0, 0);
        for (int i = 0; i < 36; i++) begin
            sample_strobes();
            bsr_tdo = data[i];
            exp_q.push_back(data[i]);
            #1;
            chk("bsr_tdo_stream", TDO, exp_q.pop_front());
            step(i == 35, 0);
        end
        chk("bsr_ex1", tap_state, 4'h1);
        sample_strobes();
        step(1, 0); sample_strobes();
        step(0, 0); sample_strobes();
        chk("bsr_ncap", ncap, 1);
        chk("bsr_nshift", nsh, 36);
        chk("bsr_nupd", nupd, 1);

        // ---- BYPASS: one-cycle TDI->TDO, no BSR strobes
        ir_scan(2'b11);
        ncap = 0; nsh = 0; nupd = 0;
        bits = 4'b1101;
        step(1, 0); sample_strobes();
        step(0, 0); sample_strobes();
        step(0, 0);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) begin
            sample_strobes();
            chk("bypass_tdo", TDO, exp_q.pop_front());
            exp_q.push_back(bits[i]);
            step(i == 3, bits[i]);
        end
        exp_q.delete();
        sample_strobes();
        step(1, 0); sample_strobes();
        step(0, 0); sample_strobes();
        chk("bypass_no_strobes", ncap + nsh + nupd, 0);

        // ---- EXTEST drives bsr_mode only after Update-IR
        ir_scan(2'b00);

        // ---- TRST while in Pause-IR
        step(1, 0); step(1, 0); step(0, 0); step(1, 0); step(0, 0);
        chk("psir_state", tap_state, 4'hB);
        u0 = upd_cnt;
        TRST = 1'b0;
        #1;
        chk("trst_async_state", tap_state, 4'hF);
        chk("trst_no_update", bsr_update, 1'b0);
        chk("trst_ir", ir_out, IR_RST);
        @(negedge TCLK);
        #1;
        TRST = 1'b1;
        cur_ir = IR_RST;
        chk("trst_upd_count", upd_cnt, u0);
        step(0, 0);
        chk("trst_to_rti", tap_state, 4'hC);

`ifdef JTAG_IDCODE_EN
        // ---- IDCODE DR scan after reset
        idv = '0;
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 32; i++) begin
            idv[i] = TDO;
            step(i == 31, 0);
        end
        chk("idcode_first_bit", idv[0], 1'b1);
        chk("idcode_value", idv, 32'h0000_0001);
        step(1, 0); step(0, 0);
        ir_scan(2'b00);
`else
        idv = '0;
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
